// File: rtl/seq_demux_rr_1to8.sv
// One-entry staging register feeding a 1-to-8 demux fabric; destination is
// either round-robin or explicit, with a single-cycle pass-through latency.

module seq_demux_rr_lane #(
  parameter int nbits = 8,
  parameter int LANE  = 0
) (
  input  logic             full,
  input  logic [2:0]       dest,
  input  logic [nbits-1:0] data,
  output logic             val,
  output logic [nbits-1:0] dout
);
  localparam logic [2:0] ID = 3'(LANE);

  assign val  = full && (dest == ID);
  assign dout = val ? data : '0;
endmodule

module seq_demux_rr_1to8 #(
  parameter int nbits = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_val,
  output logic             in_rdy,
  input  logic [nbits-1:0] in_,
  input  logic             mode,
  input  logic [2:0]       sel,
  output logic [7:0]       out_val,
  input  logic [7:0]       out_rdy,
  output logic [nbits-1:0] out0,
  output logic [nbits-1:0] out1,
  output logic [nbits-1:0] out2,
  output logic [nbits-1:0] out3,
  output logic [nbits-1:0] out4,
  output logic [nbits-1:0] out5,
  output logic [nbits-1:0] out6,
  output logic [nbits-1:0] out7,
  output logic [2:0]       rr_ptr
);
  localparam int NUM_LANES = 8;

  logic             full_q, full_d;
  logic [nbits-1:0] data_q, data_d;
  logic [2:0]       dest_q, dest_d;
  logic [2:0]       rr_ptr_q, rr_ptr_d;
  logic             in_xfer, out_xfer;

  logic [NUM_LANES-1:0][nbits-1:0] lane_data;

  // Dequeue and enqueue may coincide, so a draining entry never blocks input.
  assign out_xfer = full_q && out_rdy[dest_q];
  assign in_rdy   = !full_q || out_rdy[dest_q];
  assign in_xfer  = in_val && in_rdy;

  always_comb begin
    full_d   = full_q;
    data_d   = data_q;
    dest_d   = dest_q;
    rr_ptr_d = rr_ptr_q;
    if (in_xfer) begin
      full_d = 1'b1;
      data_d = in_;
      dest_d = mode ? sel : rr_ptr_q;
      if (!mode) rr_ptr_d = rr_ptr_q + 3'd1;
    end else if (out_xfer) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full_q   <= 1'b0;
      data_q   <= '0;
      dest_q   <= '0;
      rr_ptr_q <= '0;
    end else begin
      full_q   <= full_d;
      data_q   <= data_d;
      dest_q   <= dest_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      seq_demux_rr_lane #(.nbits(nbits), .LANE(gi)) u_lane (
        .full (full_q),
        .dest (dest_q),
        .data (data_q),
        .val  (out_val[gi]),
        .dout (lane_data[gi])
      );
    end
  endgenerate

  assign out0   = lane_data[0];
  assign out1   = lane_data[1];
  assign out2   = lane_data[2];
  assign out3   = lane_data[3];
  assign out4   = lane_data[4];
  assign out5   = lane_data[5];
  assign out6   = lane_data[6];
  assign out7   = lane_data[7];
  assign rr_ptr = rr_ptr_q;
endmodule

// File: tb/tb_seq_demux_rr_1to8.sv
// Randomized + directed bench; reference is a queue-of-one entry model plus a
// count of round-robin transfers.

module tb_seq_demux_rr_1to8;
  localparam int NB = 8;

  logic          clk;
  logic          reset;
  logic          in_val;
  logic          in_rdy;
  logic [NB-1:0] in_;
  logic          mode;
  logic [2:0]    sel;
  logic [7:0]    out_val;
  logic [7:0]    out_rdy;
  logic [NB-1:0] out0, out1, out2, out3, out4, out5, out6, out7;
  logic [2:0]    rr_ptr;
  logic [NB-1:0] outs [8];

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [NB-1:0] data;
    logic [2:0]    dest;
  } ent_t;

  ent_t        mq[$];
  int unsigned rr_cnt;

  seq_demux_rr_1to8 #(.nbits(NB)) dut (
    .clk(clk), .reset(reset), .in_val(in_val), .in_rdy(in_rdy), .in_(in_),
    .mode(mode), .sel(sel), .out_val(out_val), .out_rdy(out_rdy),
    .out0(out0), .out1(out1), .out2(out2), .out3(out3),
    .out4(out4), .out5(out5), .out6(out6), .out7(out7), .rr_ptr(rr_ptr)
  );

  assign outs[0] = out0; assign outs[1] = out1;
  assign outs[2] = out2; assign outs[3] = out3;
  assign outs[4] = out4; assign outs[5] = out5;
  assign outs[6] = out6; assign outs[7] = out7;

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: at most one entry in flight; pointer is transfer count mod 8.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      rr_cnt = 0;
    end else begin
      bit rdy, deq;
      deq = (mq.size() != 0) && out_rdy[mq[0].dest];
      rdy = (mq.size() == 0) || deq;
      if (deq) void'(mq.pop_front());
      if (in_val && rdy) begin
        ent_t e;
        e.data = in_;
        e.dest = mode ? sel : 3'(rr_cnt % 8);
        mq.push_back(e);
        if (!mode) rr_cnt++;
      end
    end
  end

  task automatic check_model();
    logic [7:0]    ev;
    logic [NB-1:0] ed;
    logic          er;
    ev = '0;
    ed = '0;
    er = 1'b1;
    if (mq.size() != 0) begin
      ev[mq[0].dest] = 1'b1;
      ed = mq[0].data;
      er = out_rdy[mq[0].dest];
    end
    chk("model_out_val", 32'(out_val), 32'(ev));
    chk("model_in_rdy", 32'(in_rdy), 32'(er));
    chk("model_rr_ptr", 32'(rr_ptr), 32'(rr_cnt % 8));
    for (int i = 0; i < 8; i++)
      chk($sformatf("model_out%0d", i), 32'(outs[i]), ev[i] ? 32'(ed) : 32'd0);
  endtask

  always @(negedge clk) check_model();

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_reset();
    #2 reset = 1'b1;
    #2 reset = 1'b0;
  endtask

  initial begin
    reset   = 1'b0;
    in_val  = 1'b0;
    in_     = '0;
    mode    = 1'b0;
    sel     = '0;
    out_rdy = '0;
    #1 reset = 1'b1;
    step();
    step();
    chk("reset_in_rdy", 32'(in_rdy), 32'd1);
    chk("reset_out_val", 32'(out_val), 32'h00);
    chk("reset_rr_ptr", 32'(rr_ptr), 32'd0);
    reset = 1'b0;

    // Round-robin sweep
    mode = 1'b0; out_rdy = 8'hFF; in_val = 1'b1;
    for (int k = 0; k < 9; k++) begin
      logic [7:0] one;
      in_ = 8'h10 + 8'(k);
      step();
      one = 8'h01 << (k % 8);
      chk("sweep_out_val", 32'(out_val), 32'(one));
      chk("sweep_data", 32'(outs[k % 8]), 32'(8'h10 + 8'(k)));
      chk("sweep_rr_ptr", 32'(rr_ptr), 32'((k + 1) % 8));
      chk("sweep_in_rdy", 32'(in_rdy), 32'd1);
    end
    in_val = 1'b0;
    step();
    chk("sweep_drained", 32'(out_val), 32'h00);

    pulse_reset();

    // Explicit select
    mode = 1'b1; sel = 3'd5; in_ = 8'hA5; in_val = 1'b1; out_rdy = 8'hFF;
    step();
    in_val = 1'b0;
    chk("sel_out_val", 32'(out_val), 32'h20);
    chk("sel_out5", 32'(out5), 32'hA5);
    chk("sel_out4", 32'(out4), 32'h00);
    chk("sel_rr_ptr", 32'(rr_ptr), 32'd0);
    step();

    // Back-pressure
    sel = 3'd3; in_ = 8'h3C; in_val = 1'b1; out_rdy = 8'hF7;
    step();
    in_ = 8'hFF; sel = 3'd1; mode = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("bp_in_rdy", 32'(in_rdy), 32'd0);
      chk("bp_out3", 32'(out3), 32'h3C);
      chk("bp_out_val", 32'(out_val), 32'h08);
      step();
    end
    in_val = 1'b0; out_rdy = 8'hFF; mode = 1'b1;
    #1 chk("bp_release_rdy", 32'(in_rdy), 32'd1);
    step();
    chk("bp_drained", 32'(out_val), 32'h00);
    chk("bp_rr_hold", 32'(rr_ptr), 32'd0);

    // Readiness of non-destination lanes is ignored
    sel = 3'd2; in_ = 8'h5A; in_val = 1'b1; out_rdy = 8'hFB;
    step();
    in_val = 1'b0;
    step();
    step();
    chk("irr_held", 32'(out_val), 32'h04);
    chk("irr_out2", 32'(out2), 32'h5A);
    out_rdy = 8'h04;
    step();
    chk("irr_drained", 32'(out_val), 32'h00);

    // Simultaneous dequeue/enqueue
    mode = 1'b0; in_ = 8'h11; in_val = 1'b1; out_rdy = 8'hFF;
    step();
    in_ = 8'h77;
    chk("simul_in_rdy", 32'(in_rdy), 32'd1);
    step();
    in_val = 1'b0;
    chk("simul_out_val", 32'(out_val), 32'h02);
    chk("simul_out1", 32'(out1), 32'h77);
    chk("simul_rr_ptr", 32'(rr_ptr), 32'd2);
    step();

    // Asynchronous reset between edges
    mode = 1'b1; sel = 3'd6; in_ = 8'h66; in_val = 1'b1; out_rdy = 8'h00;
    step();
    in_val = 1'b0;
    chk("ar_loaded", 32'(out_val), 32'h40);
    #2 reset = 1'b1;
    #1;
    chk("ar_out_val", 32'(out_val), 32'h00);
    chk("ar_in_rdy", 32'(in_rdy), 32'd1);
    chk("ar_rr_ptr", 32'(rr_ptr), 32'd0);
    #1 reset = 1'b0;
    mode = 1'b0; in_ = 8'h99; in_val = 1'b1; out_rdy = 8'hFF;
    step();
    in_val = 1'b0;
    chk("ar_first_out_val", 32'(out_val), 32'h01);
    chk("ar_first_out0", 32'(out0), 32'h99);

    // Randomized traffic against the reference
    for (int c = 0; c < 3000; c++) begin
      in_val  = ($urandom_range(0, 3) != 0);
      in_     = 8'($urandom);
      mode    = 1'($urandom);
      sel     = 3'($urandom);
      out_rdy = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom);
      step();
      if ($urandom_range(0, 199) == 0) pulse_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/seq_demux_rr_1to8.md
SEQ_DEMUX_RR_1TO8 -- requirements
Module: seq_demux_rr_1to8

Interface
REQ-001 Parameter: nbits, default 8, data width of the payload and of each of out0..out7.
REQ-002 Port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset; clears all state immediately on assertion, independent of clk.
REQ-004 Port: in_val  input  1  upstream payload valid.
REQ-005 Port: in_rdy  output  1  block can accept a payload this cycle.
REQ-006 Port: in_  input  nbits  upstream payload.
REQ-007 Port: mode  input  1  0 = round-robin destination, 1 = explicit destination from sel.
REQ-008 Port: sel  input  3  explicit destination index, used only when mode=1.
REQ-009 Port: out_val  output  8  bit i = out<i> holds a valid payload.
REQ-010 Port: out_rdy  input  8  bit i = downstream consumer i accepts this cycle.
REQ-011 Port: out0..out7  output  nbits each  per-destination payload (downstream 1-to-8 demux fabric).
REQ-012 Port: rr_ptr  output  3  current round-robin pointer, for observability.

Function
REQ-013 Block SHALL hold one payload entry: registers full (1b), data (nbits), dest (3b), plus rr_ptr (3b).
REQ-014 Input transfer SHALL occur when in_val && in_rdy at a rising clk edge.
REQ-015 Output transfer SHALL occur when full && out_rdy[dest] at a rising clk edge; out_rdy bits other than dest SHALL be ignored.
REQ-016 in_rdy SHALL equal !full || out_rdy[dest] (combinational), allowing simultaneous dequeue and enqueue in one cycle.
REQ-017 On input transfer, data <= in_, full <= 1, dest <= (mode ? sel : rr_ptr), sampled in the same cycle.
REQ-018 On output transfer with no input transfer, full <= 0; data and dest SHALL hold their values.
REQ-019 Latency SHALL be exactly one cycle: payload accepted at edge N appears on out<dest> with out_val[dest]=1 after edge N.
REQ-020 out_val[i] SHALL equal full && (dest == i); at most one out_val bit SHALL be high.
REQ-021 out<i> SHALL equal data when full && dest == i, else all zeros.
REQ-022 rr_ptr SHALL increment by one on every input transfer with mode=0, wrapping 7 -> 0; it SHALL hold otherwise, including on mode=1 transfers.
REQ-023 in_ with in_val=0 SHALL have no effect on state, regardless of mode/sel.
REQ-024 Changes of mode or sel while full SHALL NOT affect the held dest.
REQ-025 Back-pressure: while full && !out_rdy[dest], in_rdy=0 and all state SHALL hold.

Reset
REQ-026 While reset=1: full=0, data=0, dest=0, rr_ptr=0; hence in_rdy=1, out_val=8'h00, out0..out7=0.
REQ-027 Reset asserted mid-transfer SHALL discard the held payload immediately, without waiting for clk.
REQ-028 First transfer after reset deassertion SHALL be accepted on the first rising edge with in_val=1.

Verification
REQ-029 Round-robin sweep: mode=0, out_rdy=8'hFF, in_val=1, in_=8'h10..8'h18 on consecutive cycles -> out_val one-hot 8'h01,8'h02,...,8'h80,8'h01, out0=8'h10..out7=8'h17, then out0=8'h18; rr_ptr wraps 7 -> 0; in_rdy stays 1.
REQ-030 Explicit select: mode=1, sel=5, in_=8'hA5, out_rdy=8'hFF -> next cycle out_val=8'h20, out5=8'hA5, others 0; rr_ptr unchanged at 0.
REQ-031 Back-pressure: mode=1, sel=3, in_=8'h3C accepted, out_rdy=8'hF7 for 3 cycles -> out3=8'h3C held, in_rdy=0, new in_=8'hFF ignored; out_rdy=8'hFF -> out3 drains, in_rdy=1.
REQ-032 Irrelevant ready: payload for dest=2 with out_rdy=8'hFB -> no drain; set out_rdy[2]=1 -> drains.
REQ-033 Simultaneous dequeue/enqueue: full with dest=0, out_rdy=8'hFF, in_val=1, mode=0, in_=8'h77 -> same edge drains old and loads new; out_val moves to next rr_ptr destination, no bubble.
REQ-034 Async reset: full with dest=6, assert reset between clock edges -> out_val=0, in_rdy=1, rr_ptr=0 before next edge; after deassertion first transfer goes to out0 (mode=0).
